pcx_src_queue: RTL and testbench
================================

Name: pcx_src_queue

Overview:
- Crossbar-side receiver for one SPARC core's PCX request port.
- Captures the core's request, atomic flag and packet, and stores each packet in a 2-entry FIFO for its destination.
- Presents each FIFO head to the per-destination PCX arbiters.
- When an arbiter dequeues a packet, it returns the matching per-destination grant to the core.

Parameters:
- DATA_W, 124, PCX packet width.
- NDEST, 5, number of destinations: L2 banks 0-3 plus IO/FPU. Bit index equals destination.
- QDEPTH, 2, entries per destination FIFO. Fixed at 2; the core credit scheme relies on it.

Ports:
- rclk  in  1  core clock.
- arst_l  in  1  asynchronous active-low reset.
- spc_pcx_req_pq  in  NDEST  one-hot destination request, PQ stage.
- spc_pcx_atom_pq  in  1  this request and the next one form an atomic pair, PQ stage.
- spc_pcx_data_pa  in  DATA_W  packet for the previous cycle's request, PA stage.
- pcx_spc_grant_px  out  NDEST  registered per-destination grant (entry freed) to the core.
- pcx_arb_req  out  NDEST  FIFO[d] is non-empty.
- pcx_arb_atom  out  NDEST  head of FIFO[d] is the first half of an atomic pair.
- pcx_arb_sel  in  NDEST  one-hot dequeue select from the arbiters.
- pcx_data_px  out  DATA_W  dequeued packet, registered.
- pcx_dest_px  out  NDEST  one-hot destination of pcx_data_px; all-zero means no valid packet.
- pcx_srcq_err  out  1  sticky protocol error.

Behaviour:
- Reset (async, arst_l=0): FIFO pointers/counts cleared, pipeline registers cleared.
  - All outputs are 0: grant, arb_req, arb_atom, data_px, dest_px, err.
  - Reset mid-operation discards all queued packets; no grants are issued for them.
- PQ-to-PA pipeline: req and atom are registered at cycle t (req_pa, atom_pa).
- Enqueue: at t+1 the packet data_pa is written into FIFO[req_pa] at the end of the cycle. Its entry carries the atom_pa bit.
- Visibility: pcx_arb_req[d] rises at t+2. Minimum enqueue-to-arbiter latency is 2 cycles.
- Dequeue: pcx_arb_sel[d]=1 at cycle s pops the head of FIFO[d].
  - At s+1: pcx_data_px = that packet, pcx_dest_px = sel, pcx_spc_grant_px[d] = 1 for exactly one cycle.
  - Without a pop, pcx_data_px holds its old value and pcx_dest_px = 0.
- Full check at the PA write:
  - The write is accepted if count[d] < 2, or if FIFO[d] is popped in the same cycle (simultaneous push and pop on a full FIFO is legal, count stays 2).
  - Otherwise the packet is dropped and err is set.
- Empty FIFO: sel[d] with count[d]=0 sets err. No grant is issued and dest_px = 0.
- Protocol errors that also set err:
  - req_pq not one-hot and non-zero: the request is dropped.
  - sel not one-hot and non-zero: no pop.
- Atomic pairs:
  - atom_pq=1 at t obliges the core to send a second request at t+1 to the same destination with atom_pq=0.
  - Mismatched destination, or no request at t+1: err is set and both packets are still enqueued.
  - pcx_arb_atom[d] = atom bit of the FIFO[d] head.
  - The arbiter is required to select d on two consecutive cycles. The block does not enforce this.
- FIFO mechanics: 1-bit read/write pointers per destination, wrapping 1 to 0; count in range 0..2.
- err is sticky until reset.

Optional Feature:
- PCX_SRCQ_PARITY_EN defined:
  - Each entry stores one extra even-parity bit over data, computed at enqueue.
  - Parity is checked at dequeue; a mismatch sets err in the same cycle as the registered output (s+1).
  - The packet is still delivered.
- Not defined: no parity storage or check. Behaviour is otherwise identical.

Decomposition:
- Shared package pcx_pkg:
  - PCX_DATA_W, PCX_NDEST.
  - Destination index constants: PCX_DEST_L2B0..3 = 0..3, PCX_DEST_IOFPU = 4.
  - A one-hot checker function.
- Sub-module pcx_dest_fifo: one 2-entry FIFO with push, pop, data, atom bit, count, full, empty, and the optional parity bit. Instantiated NDEST times.

Test Plan:
- Single request: req=5'b00001 at t, data=0xA5..A5 at t+1; sel=5'b00001 at t+2 -> arb_req[0]=1 at t+2; data_px=0xA5..A5, dest_px=5'b00001, grant=5'b00001 at t+3.
- Fill dest 2 with packets P1, P2 with no sel; a third request with no pop -> arb_req[2] stays 1, third packet dropped, err=1; then two pops -> P1 then P2 out, two grants[2].
- Dest 3 full (P1, P2), third write P3 coincident with sel[3] -> no err; pop order is P1, P2, P3.
- Atomic pair: atom=1 with req=5'b10000 at t, then req=5'b10000 at t+1 -> arb_atom[4]=1 with the first packet at head; two consecutive sels deliver both packets and give grant[4] on two consecutive cycles.
- Error cases, each checked separately: sel[1] with FIFO[1] empty, and req=5'b00011 -> err=1, no grant, dest_px=0; assert arst_l=0 with packets queued -> all outputs 0, queues empty.

Source files
------------

// File: rtl/pcx_pkg.sv
// pcx_pkg: shared PCX widths, destination indices and a one-hot checker
package pcx_pkg;

    localparam int PCX_DATA_W     = 124;
    localparam int PCX_NDEST      = 5;
    localparam int PCX_QDEPTH     = 2;

    localparam int PCX_DEST_L2B0  = 0;
    localparam int PCX_DEST_L2B1  = 1;
    localparam int PCX_DEST_L2B2  = 2;
    localparam int PCX_DEST_L2B3  = 3;
    localparam int PCX_DEST_IOFPU = 4;

    function automatic logic pcx_is_onehot(input logic [PCX_NDEST-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/pcx_dest_fifo.sv
// pcx_dest_fifo: 2-entry packet FIFO for one PCX destination (optional parity via PCX_SRCQ_PARITY_EN)
//   rclk, arst_l : clock, async active-low reset
//   push, pop    : enqueue din/atom_in, dequeue head
//   dout,atom_out: head entry
//   count/full/empty : occupancy
//   par_err      : head parity mismatch (always 0 without PCX_SRCQ_PARITY_EN)
module pcx_dest_fifo #(
    parameter int W     = 124,
    parameter int DEPTH = 2
) (
    input  logic         rclk,
    input  logic         arst_l,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    input  logic         atom_in,
    output logic [W-1:0] dout,
    output logic         atom_out,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty,
    output logic         par_err
);

    logic [W-1:0] mem_d [2];
    logic [1:0]   mem_a;
    logic         wp, rp;
`ifdef PCX_SRCQ_PARITY_EN
    logic [1:0]   mem_p;
`endif

    // A push into a full FIFO is only issued alongside a pop, so wp==rp then;
    // the head is read combinationally before this edge overwrites it.
    always_ff @(posedge rclk)
        if (push) begin
            mem_d[wp] <= din;
            mem_a[wp] <= atom_in;
`ifdef PCX_SRCQ_PARITY_EN
            mem_p[wp] <= ^din;
`endif
        end

    always_ff @(posedge rclk or negedge arst_l)
        if (!arst_l) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            wp    <= wp ^ push;
            rp    <= rp ^ pop;
            count <= count + {1'b0, push} - {1'b0, pop};
        end

    assign dout     = mem_d[rp];
    assign atom_out = mem_a[rp];
    assign full     = count == 2'(DEPTH);
    assign empty    = count == 2'd0;

`ifdef PCX_SRCQ_PARITY_EN
    assign par_err = (^dout) ^ mem_p[rp];
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: rtl/pcx_src_queue.sv
// pcx_src_queue: crossbar receiver for one core's PCX port, per-destination 2-deep queues (PCX_SRCQ_PARITY_EN adds entry parity)
//   rclk, arst_l       : clock, async active-low reset
//   spc_pcx_req_pq/atom_pq : one-hot request and atomic flag (PQ)
//   spc_pcx_data_pa    : packet for last cycle's request (PA)
//   pcx_arb_req/atom   : per-destination queue non-empty / head is atomic first half
//   pcx_arb_sel        : one-hot dequeue select
//   pcx_data_px/dest_px, pcx_spc_grant_px : registered dequeue result and credit return
//   pcx_srcq_err       : sticky protocol/parity error
module pcx_src_queue
    import pcx_pkg::*;
#(
    parameter int DATA_W = PCX_DATA_W,
    parameter int NDEST  = PCX_NDEST,
    parameter int QDEPTH = PCX_QDEPTH
) (
    input  logic              rclk,
    input  logic              arst_l,
    input  logic [NDEST-1:0]  spc_pcx_req_pq,
    input  logic              spc_pcx_atom_pq,
    input  logic [DATA_W-1:0] spc_pcx_data_pa,
    output logic [NDEST-1:0]  pcx_spc_grant_px,
    output logic [NDEST-1:0]  pcx_arb_req,
    output logic [NDEST-1:0]  pcx_arb_atom,
    input  logic [NDEST-1:0]  pcx_arb_sel,
    output logic [DATA_W-1:0] pcx_data_px,
    output logic [NDEST-1:0]  pcx_dest_px,
    output logic              pcx_srcq_err
);

    logic [NDEST-1:0]  req_pa, full, empty, head_atom, par_err, push, pop;
    logic              atom_pa, req_ok, sel_ok, err_nx;
    logic [1:0]        count     [NDEST];
    logic [DATA_W-1:0] head_data [NDEST];
    logic [DATA_W-1:0] pop_data;

    assign req_ok = pcx_is_onehot(spc_pcx_req_pq);
    assign sel_ok = pcx_is_onehot(pcx_arb_sel);
    assign pop    = sel_ok ? pcx_arb_sel & ~empty : '0;
    // A full queue still accepts when its head leaves in the same cycle.
    assign push   = req_pa & (~full | pop);

    always_comb begin
        pop_data = pcx_data_px;
        for (int i = 0; i < NDEST; i++)
            if (pop[i]) pop_data = head_data[i];
    end

    // The second half of an atomic pair must follow at once to the same destination;
    // the check runs while the first half sits in PA and the second is in PQ.
    assign err_nx = pcx_srcq_err
                  | ((|spc_pcx_req_pq) & ~req_ok)
                  | ((|pcx_arb_sel) & ~sel_ok)
                  | (sel_ok & (|(pcx_arb_sel & empty)))
                  | (|(req_pa & ~push))
                  | (atom_pa & (spc_pcx_req_pq != req_pa))
                  | (|(pop & par_err));

    for (genvar d = 0; d < NDEST; d++) begin : g_q
        pcx_dest_fifo #(.W(DATA_W), .DEPTH(QDEPTH)) u_fifo (
            .rclk     (rclk),
            .arst_l   (arst_l),
            .push     (push[d]),
            .pop      (pop[d]),
            .din      (spc_pcx_data_pa),
            .atom_in  (atom_pa),
            .dout     (head_data[d]),
            .atom_out (head_atom[d]),
            .count    (count[d]),
            .full     (full[d]),
            .empty    (empty[d]),
            .par_err  (par_err[d])
        );
        assign pcx_arb_req[d] = count[d] != 2'd0;
    end

    assign pcx_arb_atom = head_atom & ~empty;

    always_ff @(posedge rclk or negedge arst_l)
        if (!arst_l) begin
            req_pa           <= '0;
            atom_pa          <= 1'b0;
            pcx_spc_grant_px <= '0;
            pcx_dest_px      <= '0;
            pcx_data_px      <= '0;
            pcx_srcq_err     <= 1'b0;
        end else begin
            req_pa           <= req_ok ? spc_pcx_req_pq : '0;
            atom_pa          <= req_ok & spc_pcx_atom_pq;
            pcx_spc_grant_px <= pop;
            pcx_dest_px      <= pop;
            pcx_data_px      <= pop_data;
            pcx_srcq_err     <= err_nx;
        end

endmodule

// File: tb/tb_pcx_src_queue.sv
// tb_pcx_src_queue: directed scenarios plus randomized traffic against a queue-based reference model
module tb_pcx_src_queue;
    import pcx_pkg::*;

    localparam int W = PCX_DATA_W;
    localparam int N = PCX_NDEST;

    logic         rclk = 1'b0;
    logic         arst_l = 1'b1;
    logic [N-1:0] req_pq = '0;
    logic         atom_pq = 1'b0;
    logic [W-1:0] data_pa = '0;
    logic [N-1:0] arb_sel = '0;
    logic [N-1:0] grant, arb_req, arb_atom, dest_px;
    logic [W-1:0] data_px;
    logic         err;

    int checks = 0;
    int errors = 0;

    pcx_src_queue dut (
        .rclk             (rclk),
        .arst_l           (arst_l),
        .spc_pcx_req_pq   (req_pq),
        .spc_pcx_atom_pq  (atom_pq),
        .spc_pcx_data_pa  (data_pa),
        .pcx_spc_grant_px (grant),
        .pcx_arb_req      (arb_req),
        .pcx_arb_atom     (arb_atom),
        .pcx_arb_sel      (arb_sel),
        .pcx_data_px      (data_px),
        .pcx_dest_px      (dest_px),
        .pcx_srcq_err     (err)
    );

    always #5 rclk = ~rclk;

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    // Reference model: one queue of {data, atom} per destination plus the pending PQ request.
    typedef struct packed {
        logic [W-1:0] d;
        logic         a;
    } ent_t;

    ent_t         mq[N][$];
    int           m_req = -1;
    bit           m_atom = 0;
    logic         m_err = 0;
    logic [N-1:0] m_grant = '0;
    logic [W-1:0] m_data = '0;

    function automatic logic [W-1:0] rnd_data();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < N; d++) mq[d].delete();
        m_req = -1;
        m_atom = 0;
        m_err = 0;
        m_grant = '0;
        m_data = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] popped;
        logic         nerr;
        nerr = m_err;
        popped = '0;
        if (arb_sel != '0 && $countones(arb_sel) != 1) nerr = 1;
        if ($countones(arb_sel) == 1)
            for (int d = 0; d < N; d++)
                if (arb_sel[d]) begin
                    if (mq[d].size() > 0) begin
                        popped[d] = 1;
                        m_data = mq[d].pop_front().d;
                    end else nerr = 1;
                end
        m_grant = popped;
        if (m_req >= 0) begin
            if (mq[m_req].size() < 2) mq[m_req].push_back({data_pa, m_atom});
            else nerr = 1;
            if (m_atom && req_pq != (N'(1) << m_req)) nerr = 1;
        end
        if (req_pq != '0 && $countones(req_pq) != 1) nerr = 1;
        m_req = -1;
        for (int d = 0; d < N; d++)
            if ($countones(req_pq) == 1 && req_pq[d]) m_req = d;
        m_atom = (m_req >= 0) && atom_pq;
        m_err = nerr;
    endtask

    task automatic tick();
        model_step();
        @(posedge rclk);
        #1;
    endtask

    task automatic idle_inputs();
        req_pq = '0;
        atom_pq = 0;
        data_pa = '0;
        arb_sel = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        arst_l = 0;
        @(posedge rclk);
        #1;
        arst_l = 1;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        arst_l = 0;
        @(posedge rclk);
        #1;
        checks++;
        if ({grant, arb_req, arb_atom, dest_px, err} !== '0) begin
            errors++;
            $display("FAIL reset_ctl got=%h want=0", {grant, arb_req, arb_atom, dest_px, err});
        end
        checks++;
        if (data_px !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h want=0", data_px);
        end
        arst_l = 1;
        model_reset();
        tick();
    endtask

    task automatic test_single();
        logic [W-1:0] pa5;
        pa5 = {{15{8'hA5}}, 4'hA};
        do_reset();
        req_pq = 5'b00001;
        tick();
        req_pq = '0;
        data_pa = pa5;
        tick();
        data_pa = '0;
        checks++;
        if (arb_req !== 5'b00001) begin
            errors++;
            $display("FAIL single_arb_req got=%b want=00001", arb_req);
        end
        arb_sel = 5'b00001;
        tick();
        arb_sel = '0;
        checks++;
        if ({data_px, dest_px, grant, err} !== {pa5, 5'b00001, 5'b00001, 1'b0}) begin
            errors++;
            $display("FAIL single_out data=%h dest=%b grant=%b err=%b want data=%h dest=00001 grant=00001 err=0",
                     data_px, dest_px, grant, err, pa5);
        end
        tick();
        checks++;
        if ({data_px, dest_px, grant, arb_req} !== {pa5, 5'b0, 5'b0, 5'b0}) begin
            errors++;
            $display("FAIL single_idle data=%h dest=%b grant=%b arb_req=%b want data=%h and zeros",
                     data_px, dest_px, grant, arb_req, pa5);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] p1, p2, p3;
        p1 = rnd_data();
        p2 = rnd_data();
        p3 = rnd_data();
        do_reset();
        req_pq = 5'b00100;
        tick();
        data_pa = p1;
        tick();
        data_pa = p2;
        tick();
        req_pq = '0;
        data_pa = p3;
        checks++;
        if ({arb_req[2], err} !== 2'b10) begin
            errors++;
            $display("FAIL ovf_before arb_req2=%b err=%b want 1 0", arb_req[2], err);
        end
        tick();
        data_pa = '0;
        checks++;
        if ({arb_req[2], err} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_drop arb_req2=%b err=%b want 1 1", arb_req[2], err);
        end
        arb_sel = 5'b00100;
        tick();
        checks++;
        if ({data_px, grant} !== {p1, 5'b00100}) begin
            errors++;
            $display("FAIL ovf_pop1 data=%h grant=%b want %h 00100", data_px, grant, p1);
        end
        tick();
        arb_sel = '0;
        checks++;
        if ({data_px, grant, arb_req} !== {p2, 5'b00100, 5'b0}) begin
            errors++;
            $display("FAIL ovf_pop2 data=%h grant=%b arb_req=%b want %h 00100 00000", data_px, grant, arb_req, p2);
        end
        tick();
    endtask

    task automatic test_push_pop_full();
        logic [W-1:0] p1, p2, p3;
        p1 = rnd_data();
        p2 = rnd_data();
        p3 = rnd_data();
        do_reset();
        req_pq = 5'b01000;
        tick();
        data_pa = p1;
        tick();
        data_pa = p2;
        tick();
        req_pq = '0;
        data_pa = p3;
        arb_sel = 5'b01000;
        tick();
        data_pa = '0;
        checks++;
        if ({data_px, grant, err} !== {p1, 5'b01000, 1'b0}) begin
            errors++;
            $display("FAIL full_pp_p1 data=%h grant=%b err=%b want %h 01000 0", data_px, grant, err, p1);
        end
        tick();
        checks++;
        if ({data_px, grant} !== {p2, 5'b01000}) begin
            errors++;
            $display("FAIL full_pp_p2 data=%h grant=%b want %h 01000", data_px, grant, p2);
        end
        tick();
        arb_sel = '0;
        checks++;
        if ({data_px, grant, err, arb_req} !== {p3, 5'b01000, 1'b0, 5'b0}) begin
            errors++;
            $display("FAIL full_pp_p3 data=%h grant=%b err=%b arb_req=%b want %h 01000 0 00000",
                     data_px, grant, err, arb_req, p3);
        end
        tick();
    endtask

    task automatic test_atomic();
        logic [W-1:0] a1, a2;
        a1 = rnd_data();
        a2 = rnd_data();
        do_reset();
        req_pq = 5'b10000;
        atom_pq = 1;
        tick();
        atom_pq = 0;
        data_pa = a1;
        tick();
        req_pq = '0;
        data_pa = a2;
        tick();
        data_pa = '0;
        checks++;
        if ({arb_req, arb_atom} !== {5'b10000, 5'b10000}) begin
            errors++;
            $display("FAIL atom_head arb_req=%b arb_atom=%b want 10000 10000", arb_req, arb_atom);
        end
        arb_sel = 5'b10000;
        tick();
        checks++;
        if ({data_px, grant, arb_atom} !== {a1, 5'b10000, 5'b0}) begin
            errors++;
            $display("FAIL atom_first data=%h grant=%b arb_atom=%b want %h 10000 00000", data_px, grant, arb_atom, a1);
        end
        tick();
        arb_sel = '0;
        checks++;
        if ({data_px, grant, err} !== {a2, 5'b10000, 1'b0}) begin
            errors++;
            $display("FAIL atom_second data=%h grant=%b err=%b want %h 10000 0", data_px, grant, err, a2);
        end
        tick();
    endtask

    task automatic test_atomic_mismatch();
        do_reset();
        req_pq = 5'b00001;
        atom_pq = 1;
        tick();
        req_pq = 5'b00010;
        atom_pq = 0;
        data_pa = rnd_data();
        tick();
        req_pq = '0;
        data_pa = rnd_data();
        tick();
        checks++;
        if ({arb_req, err} !== {5'b00011, 1'b1}) begin
            errors++;
            $display("FAIL atom_mismatch arb_req=%b err=%b want 00011 1", arb_req, err);
        end
    endtask

    task automatic test_errors();
        do_reset();
        arb_sel = 5'b00010;
        tick();
        arb_sel = '0;
        checks++;
        if ({err, grant, dest_px} !== {1'b1, 5'b0, 5'b0}) begin
            errors++;
            $display("FAIL empty_sel err=%b grant=%b dest=%b want 1 00000 00000", err, grant, dest_px);
        end
        do_reset();
        req_pq = 5'b00011;
        tick();
        req_pq = '0;
        data_pa = rnd_data();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL bad_req err=%b want 1", err);
        end
        tick();
        tick();
        checks++;
        if ({arb_req, grant, dest_px} !== '0) begin
            errors++;
            $display("FAIL bad_req_drop arb_req=%b grant=%b dest=%b want zeros", arb_req, grant, dest_px);
        end
        do_reset();
        arb_sel = 5'b00101;
        tick();
        arb_sel = '0;
        checks++;
        if ({err, grant} !== {1'b1, 5'b0}) begin
            errors++;
            $display("FAIL bad_sel err=%b grant=%b want 1 00000", err, grant);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_pq = 5'b00001;
        tick();
        req_pq = 5'b01000;
        data_pa = rnd_data();
        tick();
        req_pq = '0;
        data_pa = rnd_data();
        arb_sel = 5'b00001;
        tick();
        arb_sel = '0;
        arst_l = 0;
        #1;
        checks++;
        if ({grant, arb_req, arb_atom, dest_px, err} !== '0 || data_px !== '0) begin
            errors++;
            $display("FAIL reset_mid grant=%b arb_req=%b arb_atom=%b dest=%b err=%b data=%h want zeros",
                     grant, arb_req, arb_atom, dest_px, err, data_px);
        end
        @(posedge rclk);
        #1;
        arst_l = 1;
        model_reset();
        tick();
        tick();
        checks++;
        if ({arb_req, grant} !== '0) begin
            errors++;
            $display("FAIL reset_mid_empty arb_req=%b grant=%b want zeros", arb_req, grant);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_req, exp_atom;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int r, s, st;
            r = $urandom_range(0, 99);
            if (m_atom && m_req >= 0 && r < 85) req_pq = N'(1) << m_req;
            else if (r < 60) req_pq = N'(1) << $urandom_range(0, N-1);
            else if (r < 97) req_pq = '0;
            else req_pq = N'($urandom);
            atom_pq = (req_pq != '0) && !m_atom && ($urandom_range(0, 7) == 0);
            data_pa = rnd_data();
            s = $urandom_range(0, 99);
            arb_sel = '0;
            if (s < 65) begin
                st = $urandom_range(0, N-1);
                for (int k = 0; k < N; k++)
                    if (arb_sel == '0 && mq[(st + k) % N].size() > 0) arb_sel = N'(1) << ((st + k) % N);
            end else if (s < 98) arb_sel = '0;
            else arb_sel = N'(1) << $urandom_range(0, N-1);
            for (int d = 0; d < N; d++) begin
                exp_req[d] = mq[d].size() != 0;
                exp_atom[d] = mq[d].size() != 0 ? mq[d][0].a : 1'b0;
            end
            checks++;
            if ({arb_req, arb_atom, grant, dest_px, data_px, err} !== {exp_req, exp_atom, m_grant, m_grant, m_data, m_err}) begin
                errors++;
                $display("FAIL rand cyc=%0d got req=%b atom=%b grant=%b dest=%b data=%h err=%b want req=%b atom=%b grant=%b dest=%b data=%h err=%b",
                         i, arb_req, arb_atom, grant, dest_px, data_px, err,
                         exp_req, exp_atom, m_grant, m_grant, m_data, m_err);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_push_pop_full();
        test_atomic();
        test_atomic_mismatch();
        test_errors();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
